// File: rtl/first_n_of_m.sv
// Captures one frame of cluster flags/sizes on frame_start and serially extracts the
// first NUM_OUT clusters in ascending address order, one slot per clock.
module first_n_of_m #(
  parameter int unsigned NUM_VPFS     = 1536,
  parameter int unsigned NUM_OUT      = 8,
  parameter int unsigned CNT_BITS     = 3,
  parameter int unsigned ADR_BITS     = $clog2(NUM_VPFS),
  parameter int unsigned NCL_BITS     = $clog2(NUM_OUT + 1),
  parameter int unsigned OVF_CNT_BITS = 16
) (
  input  logic                         clock4x,
  input  logic                         global_reset_n,
  input  logic                         frame_start,
  input  logic [NUM_VPFS-1:0]          vpfs,
  input  logic [NUM_VPFS*CNT_BITS-1:0] cnts,
  output logic [NUM_OUT*ADR_BITS-1:0]  adr_out,
  output logic [NUM_OUT*CNT_BITS-1:0]  cnt_out,
  output logic [NUM_OUT-1:0]           vld_out,
  output logic [NCL_BITS-1:0]          nclusters,
  output logic                         overflow,
  output logic                         out_valid,
  output logic                         frame_err,
  output logic [OVF_CNT_BITS-1:0]      overflow_cnt
);

  localparam int unsigned SLOT_BITS = (NUM_OUT > 1) ? $clog2(NUM_OUT) : 1;

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  logic [0:0]                   state_q, state_d;
  logic [SLOT_BITS-1:0]         slot_q, slot_d;
  logic [NUM_VPFS-1:0]          work_vpf_q, work_vpf_d;
  logic [NUM_VPFS*CNT_BITS-1:0] work_cnt_q, work_cnt_d;
  logic [NUM_OUT*ADR_BITS-1:0]  slot_adr_q, slot_adr_d;
  logic [NUM_OUT*CNT_BITS-1:0]  slot_cnt_q, slot_cnt_d;
  logic [NUM_OUT-1:0]           slot_vld_q, slot_vld_d;
  logic [NUM_OUT*ADR_BITS-1:0]  adr_out_q, adr_out_d;
  logic [NUM_OUT*CNT_BITS-1:0]  cnt_out_q, cnt_out_d;
  logic [NUM_OUT-1:0]           vld_out_q, vld_out_d;
  logic [NCL_BITS-1:0]          ncl_q, ncl_d;
  logic                         ovf_q, ovf_d;
  logic                         out_valid_q, out_valid_d;
  logic [OVF_CNT_BITS-1:0]      ovf_cnt_q, ovf_cnt_d;

  logic [NUM_VPFS-1:0]          low_onehot;
  logic [NUM_VPFS-1:0]          residual;
  logic                         low_found;
  logic [ADR_BITS-1:0]          low_adr;
  logic [CNT_BITS-1:0]          low_cnt;
  logic [NCL_BITS-1:0]          ncl_sum;

  // Two's-complement trick isolates the lowest set bit as a one-hot mask.
  assign low_onehot = work_vpf_q & (~work_vpf_q + NUM_VPFS'(1));
  assign residual   = work_vpf_q & ~low_onehot;
  assign low_found  = |work_vpf_q;

  always_comb begin
    low_adr = '1;
    low_cnt = '0;
    for (int unsigned i = 0; i < NUM_VPFS; i++) begin
      if (low_onehot[i]) begin
        low_adr = ADR_BITS'(i);
        low_cnt = work_cnt_q[i*CNT_BITS +: CNT_BITS];
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    work_vpf_d  = work_vpf_q;
    work_cnt_d  = work_cnt_q;
    slot_adr_d  = slot_adr_q;
    slot_cnt_d  = slot_cnt_q;
    slot_vld_d  = slot_vld_q;
    adr_out_d   = adr_out_q;
    cnt_out_d   = cnt_out_q;
    vld_out_d   = vld_out_q;
    ncl_d       = ncl_q;
    ovf_d       = ovf_q;
    out_valid_d = 1'b0;
    ovf_cnt_d   = ovf_cnt_q;
    ncl_sum     = '0;

    if (frame_start) begin
      work_vpf_d = vpfs;
      work_cnt_d = cnts;
      slot_d     = '0;
      state_d    = SCAN;
    end else if (state_q == SCAN) begin
      work_vpf_d = residual;
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        if (slot_q == SLOT_BITS'(k)) begin
          slot_adr_d[k*ADR_BITS +: ADR_BITS] = low_adr;
          slot_cnt_d[k*CNT_BITS +: CNT_BITS] = low_cnt;
          slot_vld_d[k]                      = low_found;
        end
      end
      for (int unsigned k = 0; k < NUM_OUT; k++) begin
        ncl_sum = ncl_sum + NCL_BITS'(slot_vld_d[k]);
      end
      // Last slot is written and published on the same edge, so the FSM is already
      // back in IDLE during the out_valid cycle and can accept the next frame.
      if (slot_q == SLOT_BITS'(NUM_OUT - 1)) begin
        adr_out_d   = slot_adr_d;
        cnt_out_d   = slot_cnt_d;
        vld_out_d   = slot_vld_d;
        ncl_d       = ncl_sum;
        ovf_d       = |residual;
        out_valid_d = 1'b1;
        if ((|residual) && (ovf_cnt_q != '1)) begin
          ovf_cnt_d = ovf_cnt_q + OVF_CNT_BITS'(1);
        end
        state_d = IDLE;
      end else begin
        slot_d = slot_q + SLOT_BITS'(1);
      end
    end
  end

  always_ff @(posedge clock4x or negedge global_reset_n) begin
    if (!global_reset_n) begin
      state_q     <= IDLE;
      slot_q      <= '0;
      work_vpf_q  <= '0;
      work_cnt_q  <= '0;
      slot_adr_q  <= '1;
      slot_cnt_q  <= '0;
      slot_vld_q  <= '0;
      adr_out_q   <= '1;
      cnt_out_q   <= '0;
      vld_out_q   <= '0;
      ncl_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      ovf_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      work_vpf_q  <= work_vpf_d;
      work_cnt_q  <= work_cnt_d;
      slot_adr_q  <= slot_adr_d;
      slot_cnt_q  <= slot_cnt_d;
      slot_vld_q  <= slot_vld_d;
      adr_out_q   <= adr_out_d;
      cnt_out_q   <= cnt_out_d;
      vld_out_q   <= vld_out_d;
      ncl_q       <= ncl_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      ovf_cnt_q   <= ovf_cnt_d;
    end
  end

  assign adr_out      = adr_out_q;
  assign cnt_out      = cnt_out_q;
  assign vld_out      = vld_out_q;
  assign nclusters    = ncl_q;
  assign overflow     = ovf_q;
  assign out_valid    = out_valid_q;
  assign overflow_cnt = ovf_cnt_q;
  // A restart is only an error when a frame is still being scanned.
  assign frame_err    = frame_start & (state_q == SCAN);

endmodule
